// File: rtl/soc_reset_sequencer.sv
// SoC reset sequencer: brings up peripherals, the HBM subsystem and the
// matrix accelerator core in order, gated on PLL lock and HBM calibration.
// Lock loss at any point restarts the whole sequence. A software request
// either resets only the core (from RUN) or retries calibration (from ERR).
module soc_reset_sequencer #(
   parameter int unsigned LOCK_STABLE_CYCLES = 1024,
   parameter int unsigned STAGE_GAP          = 16,
   parameter int unsigned CAL_TIMEOUT        = 65535
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       locked,
   input  logic       hbm_cal_done,
   input  logic       sw_rst_req,
   output logic       rst_periph_n,
   output logic       rst_mem_n,
   output logic       rst_core_n,
   output logic       seq_done,
   output logic       cal_timeout_err,
   output logic [2:0] state_o
);

   // One counter serves every state, so it is sized for the longest interval.
   localparam int unsigned MAX_LS  = (LOCK_STABLE_CYCLES > STAGE_GAP) ? LOCK_STABLE_CYCLES : STAGE_GAP;
   localparam int unsigned CNT_MAX = (MAX_LS > CAL_TIMEOUT) ? MAX_LS : CAL_TIMEOUT;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 32'd1);

   // Terminal counts: the counter holds (cycles already spent) - so the
   // Nth cycle in a state is the one where the counter reads N-1.
   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 32'd1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 32'd1);
   localparam logic [CNT_W-1:0] CAL_LAST  = CNT_W'(CAL_TIMEOUT - 32'd1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);
   localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

   typedef enum logic [2:0] {
      ST_WAIT_LOCK = 3'd0,
      ST_PERIPH    = 3'd1,
      ST_WAIT_CAL  = 3'd2,
      ST_CORE      = 3'd3,
      ST_RUN       = 3'd4,
      ST_CORE_RST  = 3'd5,
      ST_ERR       = 3'd6,
      ST_MEM_RST   = 3'd7
   } state_e;

   // Output bundle order: {rst_periph_n, rst_mem_n, rst_core_n, seq_done, cal_timeout_err}
   function automatic logic [4:0] decode_outputs(input state_e st);
      logic [4:0] outs;
      case (st)
         ST_WAIT_LOCK: outs = 5'b00000;
         ST_PERIPH:    outs = 5'b10000;
         ST_WAIT_CAL:  outs = 5'b11000;
         ST_CORE:      outs = 5'b11000;
         ST_RUN:       outs = 5'b11110;
         ST_CORE_RST:  outs = 5'b11000;
         ST_ERR:       outs = 5'b11001;
         ST_MEM_RST:   outs = 5'b10000;
         default:      outs = 5'b00000;
      endcase
      return outs;
   endfunction

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_inc;
   logic [1:0]       locked_sync_q;
   logic [1:0]       cal_sync_q;
   logic             locked_s;
   logic             cal_s;
   logic [4:0]       outs_q, outs_d;

   assign locked_s = locked_sync_q[1];
   assign cal_s    = cal_sync_q[1];

   // Next-state, counter and output decode; lock loss overrides everything.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : (cnt_q + CNT_ONE);

      if ((state_q != ST_WAIT_LOCK) && !locked_s) begin
         state_d = ST_WAIT_LOCK;
      end else begin
         case (state_q)
            ST_WAIT_LOCK: begin
               if (locked_s && (cnt_q == LOCK_LAST)) state_d = ST_PERIPH;
               else                                  state_d = ST_WAIT_LOCK;
            end
            ST_PERIPH: begin
               if (cnt_q == GAP_LAST) state_d = ST_WAIT_CAL;
               else                   state_d = ST_PERIPH;
            end
            ST_WAIT_CAL: begin
               // Calibration completing in the timeout cycle still counts as success.
               if (cal_s)                  state_d = ST_CORE;
               else if (cnt_q == CAL_LAST) state_d = ST_ERR;
               else                        state_d = ST_WAIT_CAL;
            end
            ST_CORE: begin
               if (cnt_q == GAP_LAST) state_d = ST_RUN;
               else                   state_d = ST_CORE;
            end
            ST_RUN: begin
               if (sw_rst_req) state_d = ST_CORE_RST;
               else            state_d = ST_RUN;
            end
            ST_CORE_RST: begin
               // Further requests here are ignored so the window never stretches.
               if (cnt_q == GAP_LAST) state_d = ST_RUN;
               else                   state_d = ST_CORE_RST;
            end
            ST_ERR: begin
               if (sw_rst_req) state_d = ST_MEM_RST;
               else            state_d = ST_ERR;
            end
            ST_MEM_RST: begin
               if (cnt_q == GAP_LAST) state_d = ST_WAIT_CAL;
               else                   state_d = ST_MEM_RST;
            end
            default: state_d = ST_WAIT_LOCK;
         endcase
      end

      // Counter restarts on every state change and on any unlocked cycle in
      // WAIT_LOCK; otherwise it counts up and saturates rather than wrapping.
      if (state_d != state_q) begin
         cnt_d = CNT_ZERO;
      end else if ((state_q == ST_WAIT_LOCK) && !locked_s) begin
         cnt_d = CNT_ZERO;
      end else begin
         cnt_d = cnt_inc;
      end

      // Outputs are decoded from the next state so they switch on the entering edge.
      outs_d = decode_outputs(state_d);
   end

   // Synchronizers, state, counter and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         locked_sync_q <= 2'b00;
         cal_sync_q    <= 2'b00;
         state_q       <= ST_WAIT_LOCK;
         cnt_q         <= CNT_ZERO;
         outs_q        <= 5'b00000;
      end else begin
         locked_sync_q <= {locked_sync_q[0], locked};
         cal_sync_q    <= {cal_sync_q[0], hbm_cal_done};
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         outs_q        <= outs_d;
      end
   end

   assign rst_periph_n    = outs_q[4];
   assign rst_mem_n       = outs_q[3];
   assign rst_core_n      = outs_q[2];
   assign seq_done        = outs_q[1];
   assign cal_timeout_err = outs_q[0];
   assign state_o         = state_q;

endmodule

// File: tb/tb_soc_reset_sequencer.sv
// Scoreboard bench for soc_reset_sequencer. The stimulus process drives
// inputs on the falling edge, advances a behavioural model (time-in-stage
// bookkeeping plus an input history for the two-stage synchronizers) and
// queues the outputs expected after the next rising edge; an independent
// monitor pops and compares just after each rising edge.
`timescale 1ns/1ps
module tb_soc_reset_sequencer;

   localparam int LOCK = 8;
   localparam int GAP  = 4;
   localparam int TO   = 20;

   localparam int S_WL  = 0;
   localparam int S_PE  = 1;
   localparam int S_WC  = 2;
   localparam int S_CO  = 3;
   localparam int S_RUN = 4;
   localparam int S_CR  = 5;
   localparam int S_ERR = 6;
   localparam int S_MR  = 7;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       locked;
   logic       hbm_cal_done;
   logic       sw_rst_req;
   logic       rst_periph_n;
   logic       rst_mem_n;
   logic       rst_core_n;
   logic       seq_done;
   logic       cal_timeout_err;
   logic [2:0] state_o;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [2:0] st;
      logic       periph;
      logic       mem;
      logic       core;
      logic       done;
      logic       err;
   } exp_t;

   exp_t exp_q[$];

   // Behavioural model state
   int m_state;
   int m_age;       // full cycles already spent in m_state
   int m_run;       // consecutive synchronized-lock cycles while waiting for lock
   bit lk_hist[2];  // [0] = last sampled input, [1] = synchronized value
   bit cal_hist[2];

   soc_reset_sequencer #(
      .LOCK_STABLE_CYCLES(LOCK),
      .STAGE_GAP(GAP),
      .CAL_TIMEOUT(TO)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .locked(locked),
      .hbm_cal_done(hbm_cal_done),
      .sw_rst_req(sw_rst_req),
      .rst_periph_n(rst_periph_n),
      .rst_mem_n(rst_mem_n),
      .rst_core_n(rst_core_n),
      .seq_done(seq_done),
      .cal_timeout_err(cal_timeout_err),
      .state_o(state_o)
   );

   always #5 clk = ~clk;

   // Output levels for each state, straight from the reset-release table.
   function automatic exp_t expect_for(input int st);
      exp_t e;
      e.st     = 3'(st);
      e.periph = (st != S_WL);
      e.mem    = !(st == S_WL || st == S_PE || st == S_MR);
      e.core   = (st == S_RUN);
      e.done   = (st == S_RUN);
      e.err    = (st == S_ERR);
      return e;
   endfunction

   function automatic void model_reset();
      m_state     = S_WL;
      m_age       = 0;
      m_run       = 0;
      lk_hist[0]  = 1'b0;
      lk_hist[1]  = 1'b0;
      cal_hist[0] = 1'b0;
      cal_hist[1] = 1'b0;
   endfunction

   // Advance the model across one rising edge with the given inputs applied.
   function automatic void model_edge(input bit lk, input bit cal, input bit sw);
      int  nxt;
      bit  ls;
      bit  cs;
      ls  = lk_hist[1];
      cs  = cal_hist[1];
      nxt = m_state;
      if (m_state != S_WL && !ls) begin
         nxt = S_WL;
      end else begin
         case (m_state)
            S_WL: begin
               if (ls) m_run = m_run + 1;
               else    m_run = 0;
               if (m_run == LOCK) nxt = S_PE;
            end
            S_PE:  if (m_age + 1 == GAP) nxt = S_WC;
            S_CO:  if (m_age + 1 == GAP) nxt = S_RUN;
            S_CR:  if (m_age + 1 == GAP) nxt = S_RUN;
            S_MR:  if (m_age + 1 == GAP) nxt = S_WC;
            S_WC: begin
               if (cs)                  nxt = S_CO;
               else if (m_age + 1 == TO) nxt = S_ERR;
            end
            S_RUN: if (sw) nxt = S_CR;
            S_ERR: if (sw) nxt = S_MR;
            default: nxt = S_WL;
         endcase
      end
      if (nxt != m_state) begin
         m_state = nxt;
         m_age   = 0;
         m_run   = 0;
      end else begin
         m_age = m_age + 1;
      end
      lk_hist[1]  = lk_hist[0];
      lk_hist[0]  = lk;
      cal_hist[1] = cal_hist[0];
      cal_hist[0] = cal;
   endfunction

   task automatic step(input bit lk, input bit cal, input bit sw);
      @(negedge clk);
      locked       = lk;
      hbm_cal_done = cal;
      sw_rst_req   = sw;
      model_edge(lk, cal, sw);
      exp_q.push_back(expect_for(m_state));
   endtask

   task automatic run_until(input int target, input bit lk, input bit cal, input int budget);
      int n;
      n = 0;
      while (m_state != target && n < budget) begin
         step(lk, cal, 1'b0);
         n++;
      end
      if (m_state != target) begin
         checks++;
         failures++;
         $display("FAIL wait_state: model in state %0d, wanted %0d within %0d cycles", m_state, target, budget);
      end
   endtask

   task automatic check_all_zero(input string name);
      logic [7:0] got;
      got = {state_o, rst_periph_n, rst_mem_n, rst_core_n, seq_done, cal_timeout_err};
      checks++;
      if (got !== 8'h00) begin
         failures++;
         $display("FAIL %s: got state=%0d outs=%b, required state=0 outs=00000", name, got[7:5], got[4:0]);
      end
   endtask

   // Asynchronous reset pulse placed between clock edges, checked while low.
   task automatic async_reset_pulse();
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_all_zero("async_rst");
      #1 rst_n = 1'b1;
      model_reset();
   endtask

   // Monitor: compare queued expectation just after each rising edge.
   exp_t       mon_e;
   logic [7:0] mon_got;
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            mon_e   = exp_q.pop_front();
            mon_got = {state_o, rst_periph_n, rst_mem_n, rst_core_n, seq_done, cal_timeout_err};
            checks++;
            if (mon_got !== mon_e) begin
               failures++;
               $display("FAIL out_cmp t=%0t: got state=%0d periph=%b mem=%b core=%b done=%b err=%b, required state=%0d periph=%b mem=%b core=%b done=%b err=%b",
                        $time, mon_got[7:5], mon_got[4], mon_got[3], mon_got[2], mon_got[1], mon_got[0],
                        mon_e.st, mon_e.periph, mon_e.mem, mon_e.core, mon_e.done, mon_e.err);
            end
         end
      end
   end

   // Stimulus
   initial begin
      bit r_lk;
      bit r_cal;
      bit r_sw;
      int drain;
      rst_n        = 1'b0;
      locked       = 1'b0;
      hbm_cal_done = 1'b0;
      sw_rst_req   = 1'b0;
      model_reset();

      // Reset held across several edges, inputs high to show they are ignored
      @(posedge clk);
      locked       = 1'b1;
      hbm_cal_done = 1'b1;
      repeat (2) @(posedge clk);
      #3 check_all_zero("reset_state");
      locked       = 1'b0;
      hbm_cal_done = 1'b0;
      #1 rst_n = 1'b1;

      // Nominal bring-up, calibration reported at cycle 30
      for (int i = 0; i < 29; i++) step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0);
      run_until(S_RUN, 1'b1, 1'b1, 20);

      // Core-only reset, with a second request inside the window
      step(1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0);

      // Lock loss lands in the same cycle as a software request in RUN
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);

      // Lock glitch after 5 good cycles restarts the stability count
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 14; i++) step(1'b1, 1'b1, 1'b0);
      run_until(S_RUN, 1'b1, 1'b1, 60);

      // Calibration timeout, ERR hold, memory reset retry
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
      run_until(S_ERR, 1'b1, 1'b0, 80);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1);
      run_until(S_WC, 1'b1, 1'b0, 10);

      // Calibration appears in exactly the last allowed WAIT_CAL cycle
      for (int i = 0; i < 17; i++) step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0);
      run_until(S_RUN, 1'b1, 1'b1, 20);

      // Asynchronous reset mid-RUN, then full nominal sequence again
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
      async_reset_pulse();
      for (int i = 0; i < 29; i++) step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0);
      run_until(S_RUN, 1'b1, 1'b1, 20);

      // Randomized traffic
      r_cal = 1'b1;
      for (int i = 0; i < 400; i++) begin
         r_lk = ($urandom_range(0, 39) != 0);
         if ($urandom_range(0, 15) == 0) r_cal = ~r_cal;
         r_sw = ($urandom_range(0, 5) == 0);
         step(r_lk, r_cal, r_sw);
      end

      // Drain the scoreboard with a bounded wait
      drain = 0;
      while (exp_q.size() > 0 && drain < 5) begin
         @(posedge clk);
         #2;
         drain++;
      end
      if (exp_q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
